// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seven_segment_pkg;

    localparam int         DIGIT_WIDTH = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } scan_state_e;

    // Any nibble above 9 cannot be driven as a decimal digit.
    function automatic logic is_invalid_bcd(input logic [DIGIT_WIDTH-1:0] nibble);
        return nibble > BCD_MAX;
    endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Loadable down-counter that times both the BLANK and SHOW slots of the scanner.
module scan_slot_timer #(
    parameter int CNT_W = 2
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Load,
    input  logic [CNT_W-1:0] i_Load_Value,
    input  logic             i_Run,
    output logic             o_Done
);

    logic [CNT_W-1:0] cnt_q;

    // Saturates at zero so an idle timer never wraps.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            cnt_q <= '0;
        end else if (i_Load) begin
            cnt_q <= i_Load_Value;
        end else if (i_Run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign o_Done = (cnt_q == '0);

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS display digits through one shared registered
// decoder, with per-digit blanking for decoder settling and leading-zero suppression.
module seven_segment_scan_ctrl
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int SCAN_DIV     = 25000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                              i_Clk,
    input  logic                              i_Reset,
    input  logic                              i_Enable,
    input  logic [DIGIT_WIDTH*NUM_DIGITS-1:0] i_Digits,
    input  logic                              i_Suppress_Zeros,
    output logic [DIGIT_WIDTH-1:0]            o_Decoder_Binary,
    output logic [NUM_DIGITS-1:0]             o_Digit_Select,
    output logic                              o_Frame_Start,
    output logic                              o_Invalid_Digit
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e                            state_q;
    logic [IDX_W-1:0]                       idx_q;
    logic [NUM_DIGITS-1:0][DIGIT_WIDTH-1:0] snap_q;
    logic                                   supp_q;
    logic [DIGIT_WIDTH-1:0]                 dec_q;
    logic [NUM_DIGITS-1:0]                  sel_q;
    logic                                   frame_q;
    logic                                   inv_q;

    logic [NUM_DIGITS-1:0][DIGIT_WIDTH-1:0] digits_in;
    logic [NUM_DIGITS-1:0]                  lead_zero;
    logic [NUM_DIGITS-1:0]                  onehot_d;
    logic [IDX_W-1:0]                       idx_d;
    logic                                   masked_d;
    logic                                   tmr_load_d;
    logic [CNT_W-1:0]                       tmr_val_d;
    logic                                   tmr_done;

    assign digits_in = i_Digits;

    always_comb begin
        // lead_zero[i]: nibbles i..top of the snapshot are all zero.
        lead_zero = '0;
        lead_zero[NUM_DIGITS-1] = (snap_q[NUM_DIGITS-1] == '0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lead_zero[i] = (snap_q[i] == '0) && lead_zero[i+1];
        end

        onehot_d        = '0;
        onehot_d[idx_q] = 1'b1;

        idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        masked_d = is_invalid_bcd(snap_q[idx_q]) ||
                   (supp_q && (idx_q != '0) && lead_zero[idx_q]);
    end

    // Timer reloads coincide exactly with the FSM's slot transitions below.
    always_comb begin
        tmr_load_d = 1'b0;
        tmr_val_d  = BLANK_LOAD;
        if (i_Enable) begin
            case (state_q)
                ST_IDLE: begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = BLANK_LOAD;
                end
                ST_BLANK: begin
                    tmr_load_d = tmr_done;
                    tmr_val_d  = SHOW_LOAD;
                end
                ST_SHOW: begin
                    tmr_load_d = tmr_done;
                    tmr_val_d  = BLANK_LOAD;
                end
                default: begin
                    tmr_load_d = 1'b0;
                    tmr_val_d  = BLANK_LOAD;
                end
            endcase
        end
    end

    scan_slot_timer #(
        .CNT_W (CNT_W)
    ) u_slot_timer (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Load       (tmr_load_d),
        .i_Load_Value (tmr_val_d),
        .i_Run        (state_q != ST_IDLE),
        .o_Done       (tmr_done)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            supp_q  <= 1'b0;
            dec_q   <= '0;
            sel_q   <= '0;
            frame_q <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            inv_q   <= 1'b0;
            if (!i_Enable) begin
                // Decoder code is left as-is; only the selects go dark.
                state_q <= ST_IDLE;
                sel_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_BLANK;
                        idx_q   <= '0;
                        snap_q  <= digits_in;
                        supp_q  <= i_Suppress_Zeros;
                        dec_q   <= digits_in[0];
                        sel_q   <= '0;
                        frame_q <= 1'b1;
                    end
                    ST_BLANK: begin
                        if (tmr_done) begin
                            state_q <= ST_SHOW;
                            sel_q   <= masked_d ? '0 : onehot_d;
                            inv_q   <= is_invalid_bcd(snap_q[idx_q]);
                        end
                    end
                    ST_SHOW: begin
                        if (tmr_done) begin
                            state_q <= ST_BLANK;
                            sel_q   <= '0;
                            idx_q   <= idx_d;
                            if (idx_d == '0) begin
                                // New frame: take a fresh, tear-free snapshot.
                                snap_q  <= digits_in;
                                supp_q  <= i_Suppress_Zeros;
                                dec_q   <= digits_in[0];
                                frame_q <= 1'b1;
                            end else begin
                                dec_q <= snap_q[idx_d];
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        sel_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_Decoder_Binary = dec_q;
    assign o_Digit_Select   = sel_q;
    assign o_Frame_Start    = frame_q;
    assign o_Invalid_Digit  = inv_q;

endmodule
